// File: rtl/hazard_unit.sv
// hazard_unit: pipeline stall/flush/freeze control and halt sequencing.
// Outputs are combinational from the registered state and current inputs.
module hazard_unit #(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_id_valid,
  input  logic [3:0]  if_id_regrs,
  input  logic [3:0]  if_id_regrt,
  input  logic        if_id_uses_rs,
  input  logic        if_id_uses_rt,
  input  logic        if_id_halt,
  input  logic        id_ex_memread,
  input  logic [3:0]  id_ex_regdest,
  input  logic        ex_branch_taken,
  input  logic        mem_busy,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_bubble,
  output logic        if_id_flush,
  output logic        pipe_freeze,
  output logic        halted,
  output logic [15:0] stall_cycles
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES);

  logic [1:0] state;
  logic [1:0] state_nx;
  logic [2:0] cnt;
  logic [2:0] cnt_nx;
  logic       load_use;
  logic       halt_req;
  logic       pc_en;
  logic       if_en;
  logic       bubble;
  logic       flush;
  logic       freeze;
  logic       stall_inc;

  assign load_use = if_id_valid & id_ex_memread &
                    (id_ex_regdest != 4'd0) &
                    ((if_id_uses_rs & (if_id_regrs == id_ex_regdest)) |
                     (if_id_uses_rt & (if_id_regrt == id_ex_regdest)));

  assign halt_req = if_id_valid & if_id_halt;

  // Per-state control decode and next-state selection.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pc_en    = 1'b1;
    if_en    = 1'b1;
    bubble   = 1'b0;
    flush    = 1'b0;
    freeze   = 1'b0;
    unique case (1'b1)
      (state == RUN): begin
        if (mem_busy) begin
          pc_en  = 1'b0;
          if_en  = 1'b0;
          freeze = 1'b1;
        end else if (ex_branch_taken) begin
          bubble = 1'b1;
          flush  = 1'b1;
        end else if (load_use) begin
          pc_en  = 1'b0;
          if_en  = 1'b0;
          bubble = 1'b1;
        end else if (halt_req) begin
          pc_en    = 1'b0;
          if_en    = 1'b0;
          state_nx = DRAIN;
          cnt_nx   = DRAIN_INIT;
        end
      end
      (state == DRAIN): begin
        pc_en  = 1'b0;
        if_en  = 1'b0;
        bubble = 1'b1;
        freeze = mem_busy;
        if (!mem_busy) begin
          cnt_nx = cnt - 3'd1;
          if (cnt == 3'd1)
            state_nx = HALTED;
        end
      end
      default: begin
        pc_en  = 1'b0;
        if_en  = 1'b0;
        bubble = 1'b1;
      end
    endcase
  end

  assign stall_inc = (state == RUN) & ~pc_en;

  // While reset is held the pipeline runs freely with no hazard action.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    pipe_freeze  = 1'b0;
    halted       = 1'b0;
    if (rst_n) begin
      pc_write     = pc_en;
      if_id_write  = if_en;
      id_ex_bubble = bubble;
      if_id_flush  = flush;
      pipe_freeze  = freeze;
      halted       = (state == HALTED);
    end
  end

  // State, drain counter and saturating stall counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= RUN;
      cnt          <= 3'd0;
      stall_cycles <= 16'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (stall_inc && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: table vectors, directed corner sequences and random
// stimulus checked against a behavioural model of the hazard rules.
module tb_hazard_unit;

  localparam int DC = 3;

  typedef struct packed {
    logic       rst_n;
    logic       valid;
    logic [3:0] rs;
    logic [3:0] rt;
    logic       urs;
    logic       urt;
    logic       halt;
    logic       memread;
    logic [3:0] rd;
    logic       br;
    logic       busy;
  } in_t;

  typedef struct {
    in_t         i;
    logic [5:0]  ctl;
    logic [15:0] st;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_id_valid;
  logic [3:0]  if_id_regrs;
  logic [3:0]  if_id_regrt;
  logic        if_id_uses_rs;
  logic        if_id_uses_rt;
  logic        if_id_halt;
  logic        id_ex_memread;
  logic [3:0]  id_ex_regdest;
  logic        ex_branch_taken;
  logic        mem_busy;
  logic        pc_write;
  logic        if_id_write;
  logic        id_ex_bubble;
  logic        if_id_flush;
  logic        pipe_freeze;
  logic        halted;
  logic [15:0] stall_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  int m_mode = 0;  // 0 run, 1 drain, 2 halted
  int m_left = 0;
  int m_stalls = 0;
  logic seen_halted;

  hazard_unit #(.DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_id_valid(if_id_valid),
    .if_id_regrs(if_id_regrs), .if_id_regrt(if_id_regrt),
    .if_id_uses_rs(if_id_uses_rs), .if_id_uses_rt(if_id_uses_rt),
    .if_id_halt(if_id_halt),
    .id_ex_memread(id_ex_memread), .id_ex_regdest(id_ex_regdest),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
    .pipe_freeze(pipe_freeze), .halted(halted),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic in_t mk(logic r, logic va, logic [3:0] rs,
                             logic [3:0] rt, logic urs, logic urt,
                             logic h, logic mr, logic [3:0] rd,
                             logic br, logic bz);
    in_t v;
    v.rst_n = r; v.valid = va; v.rs = rs; v.rt = rt;
    v.urs = urs; v.urt = urt; v.halt = h; v.memread = mr;
    v.rd = rd; v.br = br; v.busy = bz;
    return v;
  endfunction

  function automatic bit hazard(in_t v);
    bit hit_rs = v.urs && (v.rs == v.rd);
    bit hit_rt = v.urt && (v.rt == v.rd);
    return v.valid && v.memread && (v.rd != 0) && (hit_rs || hit_rt);
  endfunction

  // {pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_freeze, halted}
  function automatic logic [5:0] model_ctl(in_t v);
    if (!v.rst_n) return 6'b110000;
    if (m_mode == 2) return 6'b001001;
    if (m_mode == 1) return {4'b0010, v.busy, 1'b0};
    if (v.busy) return 6'b000010;
    if (v.br) return 6'b111100;
    if (hazard(v)) return 6'b001000;
    if (v.valid && v.halt) return 6'b000000;
    return 6'b110000;
  endfunction

  task automatic model_update(in_t v);
    logic [5:0] c = model_ctl(v);
    if (!v.rst_n) begin
      m_mode = 0; m_left = 0; m_stalls = 0;
    end else if (m_mode == 0) begin
      if (!c[5]) m_stalls = (m_stalls < 65535) ? m_stalls + 1 : 65535;
      if (!v.busy && !v.br && !hazard(v) && v.valid && v.halt) begin
        m_mode = 1; m_left = DC;
      end
    end else if (m_mode == 1 && !v.busy) begin
      if (m_left == 1) m_mode = 2;
      else m_left = m_left - 1;
    end
  endtask

  task automatic check(string nm, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic apply(in_t v);
    rst_n = v.rst_n; if_id_valid = v.valid;
    if_id_regrs = v.rs; if_id_regrt = v.rt;
    if_id_uses_rs = v.urs; if_id_uses_rt = v.urt;
    if_id_halt = v.halt; id_ex_memread = v.memread;
    id_ex_regdest = v.rd; ex_branch_taken = v.br;
    mem_busy = v.busy;
  endtask

  task automatic step(in_t v, bit chk, string nm,
                      bit use_tbl, logic [21:0] tbl);
    logic [21:0] want;
    logic [21:0] got;
    apply(v);
    @(negedge clk);
    want = use_tbl ? tbl : {model_ctl(v), 16'(m_stalls)};
    got = {pc_write, if_id_write, id_ex_bubble, if_id_flush,
           pipe_freeze, halted, stall_cycles};
    seen_halted = halted;
    if (chk) check(nm, 32'(got), 32'(want));
    @(posedge clk);
    model_update(v);
    #1;
  endtask

  in_t IDL, RST, v;
  vec_t tbl[$];
  int first_h;

  initial begin
    IDL = mk(1,0,0,0,0,0,0,0,0,0,0);
    RST = IDL; RST.rst_n = 0;
    apply(RST);
    #1;

    tbl.push_back('{mk(0,0,0,0,0,0,0,0,0,0,0), 6'b110000, 16'd0});
    tbl.push_back('{mk(0,1,5,0,1,0,1,1,5,1,1), 6'b110000, 16'd0});
    tbl.push_back('{mk(1,0,0,0,0,0,0,0,0,0,0), 6'b110000, 16'd0});
    tbl.push_back('{mk(1,1,5,0,1,0,0,1,5,0,0), 6'b001000, 16'd0});
    tbl.push_back('{mk(1,1,0,0,0,0,0,0,0,0,0), 6'b110000, 16'd1});
    tbl.push_back('{mk(1,1,0,0,1,0,0,1,0,0,0), 6'b110000, 16'd1});
    tbl.push_back('{mk(1,1,5,0,1,0,0,1,5,1,0), 6'b111100, 16'd1});
    tbl.push_back('{mk(1,1,2,7,0,1,0,1,7,0,0), 6'b001000, 16'd1});
    tbl.push_back('{mk(1,1,2,7,0,0,0,1,7,0,0), 6'b110000, 16'd2});
    tbl.push_back('{mk(1,0,7,7,1,1,0,1,7,0,0), 6'b110000, 16'd2});
    tbl.push_back('{mk(1,1,5,0,1,0,0,1,5,0,1), 6'b000010, 16'd2});
    tbl.push_back('{mk(1,1,0,0,0,0,1,0,0,1,1), 6'b000010, 16'd3});
    tbl.push_back('{mk(1,1,0,0,0,0,1,0,0,1,0), 6'b111100, 16'd4});
    tbl.push_back('{mk(1,0,0,0,0,0,1,0,0,0,0), 6'b110000, 16'd4});
    tbl.push_back('{mk(1,1,3,0,1,0,1,1,3,0,0), 6'b001000, 16'd4});
    tbl.push_back('{mk(1,0,0,0,0,0,0,0,0,0,0), 6'b110000, 16'd5});
    foreach (tbl[k])
      step(tbl[k].i, 1, $sformatf("tbl%0d", k), 1, {tbl[k].ctl, tbl[k].st});

    // mem_busy for 4 cycles hides a load-use, which then stalls once
    step(RST, 1, "busy_rst", 0, '0);
    for (int k = 0; k < 4; k++) begin
      v = mk(1,1,5,0,1,0,0,1,5,0,1);
      step(v, 1, $sformatf("busy_lu%0d", k), 0, '0);
    end
    v.busy = 0;
    step(v, 1, "lu_after_busy", 0, '0);
    step(IDL, 1, "busy_end", 0, '0);
    check("busy_stalls", 32'(stall_cycles), 32'd5);

    // halt entry, two busy cycles in drain, halted 6 cycles later
    step(RST, 1, "halt_rst", 0, '0);
    v = IDL; v.valid = 1; v.halt = 1;
    step(v, 1, "halt_entry", 0, '0);
    first_h = 0;
    for (int k = 1; k <= 12; k++) begin
      v = IDL; v.busy = (k <= 2); v.br = (k == 3);
      step(v, 1, $sformatf("drain%0d", k), 0, '0);
      if (seen_halted && first_h == 0) first_h = k;
    end
    check("halt_latency", 32'(first_h), 32'd6);
    v = IDL; v.br = 1; v.busy = 1;
    step(v, 1, "halted_hold", 0, '0);

    // saturate the stall counter, then reset mid-drain
    step(RST, 1, "sat_rst", 0, '0);
    v = IDL; v.busy = 1;
    for (int k = 0; k < 65540; k++) step(v, 0, "sat", 0, '0);
    check("stall_sat", 32'(stall_cycles), 32'hFFFF);
    step(v, 1, "sat_hold", 0, '0);
    v = IDL; v.valid = 1; v.halt = 1;
    step(v, 1, "sat_halt", 0, '0);
    step(IDL, 1, "sat_drain", 0, '0);
    step(RST, 1, "mid_drain_rst", 0, '0);
    step(IDL, 1, "post_rst", 0, '0);
    check("post_rst_stall", 32'(stall_cycles), 32'd0);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      v.rst_n   = ($urandom_range(63) != 0);
      v.valid   = ($urandom_range(3) != 0);
      v.rs      = 4'($urandom_range(3));
      v.rt      = 4'($urandom_range(3));
      v.urs     = 1'($urandom);
      v.urt     = 1'($urandom);
      v.halt    = ($urandom_range(19) == 0);
      v.memread = 1'($urandom);
      v.rd      = 4'($urandom_range(3));
      v.br      = ($urandom_range(7) == 0);
      v.busy    = ($urandom_range(3) == 0);
      step(v, 1, $sformatf("rnd%0d", k), 0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter DRAIN_CYCLES, default 3: cycles spent in DRAIN after a halt leaves ID; legal range 1..7.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 if_id_valid  input  1  IF/ID holds a real instruction (0 = bubble).
REQ-005 if_id_regrs  input  4  source register 1 of the instruction in ID.
REQ-006 if_id_regrt  input  4  source register 2 of the instruction in ID.
REQ-007 if_id_uses_rs  input  1  instruction in ID reads regrs.
REQ-008 if_id_uses_rt  input  1  instruction in ID reads regrt.
REQ-009 if_id_halt  input  1  instruction in ID is HLT.
REQ-010 id_ex_memread  input  1  instruction in EX is a load.
REQ-011 id_ex_regdest  input  4  destination register of the instruction in EX.
REQ-012 ex_branch_taken  input  1  branch in EX resolved taken this cycle.
REQ-013 mem_busy  input  1  data/instruction memory multi-cycle access in progress.
REQ-014 pc_write  output  1  PC update enable.
REQ-015 if_id_write  output  1  IF/ID register write enable.
REQ-016 id_ex_bubble  output  1  load a NOP into ID/EX instead of decoded instruction.
REQ-017 if_id_flush  output  1  clear IF/ID (valid=0) at next edge.
REQ-018 pipe_freeze  output  1  hold every pipeline register (EX/MEM, MEM/WB included).
REQ-019 halted  output  1  processor fully halted.
REQ-020 stall_cycles  output  16  count of RUN-state cycles with pc_write=0.

Function
REQ-021 State machine has three states: RUN, DRAIN, HALTED; state, drain counter and stall_cycles are registered; all other outputs are combinational from state and current inputs (same-cycle response).
REQ-022 load_use = if_id_valid & id_ex_memread & (id_ex_regdest != 0) & ((if_id_uses_rs & regrs==regdest) | (if_id_uses_rt & regrt==regdest)); register 0 never causes a stall.
REQ-023 RUN priority, highest first: mem_busy, ex_branch_taken, load_use, halt, none.
REQ-024 RUN, mem_busy=1: pipe_freeze=1, pc_write=0, if_id_write=0, id_ex_bubble=0, if_id_flush=0; all other conditions ignored that cycle.
REQ-025 RUN, branch taken (no mem_busy): pc_write=1, if_id_flush=1, id_ex_bubble=1, if_id_write=1; a load_use or halt in ID the same cycle is discarded.
REQ-026 RUN, load_use (no higher condition): pc_write=0, if_id_write=0, id_ex_bubble=1; stall lasts exactly one cycle because the bubble clears id_ex_memread.
REQ-027 RUN, if_id_valid & if_id_halt (no higher condition): pc_write=0, if_id_write=0, id_ex_bubble=0; next state DRAIN, drain counter loaded with DRAIN_CYCLES.
REQ-028 RUN, no condition: pc_write=1, if_id_write=1, all other control outputs 0.
REQ-029 DRAIN: pc_write=0, if_id_write=0, id_ex_bubble=1; counter decrements each cycle with mem_busy=0; at counter==1 with mem_busy=0 next state HALTED.
REQ-030 DRAIN with mem_busy=1: pipe_freeze=1, counter holds; ex_branch_taken and load_use ignored in DRAIN.
REQ-031 HALTED: halted=1, pc_write=0, if_id_write=0, id_ex_bubble=1, pipe_freeze=0; state left only by reset.
REQ-032 stall_cycles increments by 1 in every RUN cycle with pc_write=0 (mem_busy, load_use, halt-entry cycle); saturates at 16'hFFFF; never counts in DRAIN/HALTED.
REQ-033 halted=0 in RUN and DRAIN.

Reset
REQ-034 rst_n=0 at a rising edge: state=RUN, drain counter=0, stall_cycles=0, from any state including mid-DRAIN or mid-freeze.
REQ-035 While rst_n=0: pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=0, pipe_freeze=0, halted=0.

Verification
REQ-036 id_ex_memread=1, regdest=5, if_id_regrs=5, uses_rs=1, valid=1 -> one cycle pc_write=0, id_ex_bubble=1, stall_cycles 0->1; regdest=0 same case -> no stall.
REQ-037 load_use and ex_branch_taken same cycle -> if_id_flush=1, id_ex_bubble=1, pc_write=1, stall_cycles unchanged.
REQ-038 mem_busy=1 for 4 cycles with load_use present -> pipe_freeze=1 for 4 cycles, stall_cycles +4, then one load_use stall cycle (+1).
REQ-039 HLT in ID, DRAIN_CYCLES=3, mem_busy pulse 2 cycles during DRAIN -> halted=1 exactly 6 cycles after halt-entry cycle, remains 1 until rst_n=0.
REQ-040 stall_cycles preset near 16'hFFFE via sustained mem_busy -> saturates at 16'hFFFF; rst_n=0 mid-DRAIN -> next cycle state RUN, halted=0, stall_cycles=0.
